// File: rtl/color_pkg.sv
// Colour set shared by the flag renderers.
// rgb_t is a packed 12-bit RGB triple (4 bits per channel).
// Named colours: BLACK, FLAG_GOLD (finial), IC_SILVER (pole), FLAG_GREEN (cloth).
package color_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t BLACK      = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t FLAG_GOLD  = '{r: 4'hF, g: 4'hC, b: 4'h2};
  localparam rgb_t IC_SILVER  = '{r: 4'hC, g: 4'hC, b: 4'hD};
  localparam rgb_t FLAG_GREEN = '{r: 4'h1, g: 4'h9, b: 4'h3};
endpackage

// File: rtl/flag_anim_renderer_if.sv
// Bus between the overlay pipeline and flag_anim_renderer.
// Signals:
//   frame_start, raise_req, lower_req : single-cycle pulses into the renderer
//   x, y                              : current pixel coordinates (10 bits)
//   color, enable                     : registered pixel result (1-cycle latency)
//   moving, done                      : animation status
//   dbg_state, dbg_cloth_y            : FSM state and cloth position for observation
// Handshake: there is no valid/ready pair. Every input is sampled on each
// rising clk edge; a pulse is "asserted" for exactly the cycles it is high, and
// the renderer never back-pressures. Outputs are valid every cycle after reset.
interface flag_anim_renderer_if;
  import color_pkg::*;

  logic       frame_start;
  logic       raise_req;
  logic       lower_req;
  logic [9:0] x;
  logic [9:0] y;
  rgb_t       color;
  logic       enable;
  logic       moving;
  logic       done;
  logic [1:0] dbg_state;
  logic [9:0] dbg_cloth_y;

  modport master (
    output frame_start, raise_req, lower_req, x, y,
    input  color, enable, moving, done, dbg_state, dbg_cloth_y
  );

  modport slave (
    input  frame_start, raise_req, lower_req, x, y,
    output color, enable, moving, done, dbg_state, dbg_cloth_y
  );
endinterface

// File: rtl/flag_anim_renderer.sv
// Animated flag renderer: finial, pole and a cloth that can be raised/lowered
// along the pole and waves column-by-column, frame by frame.
// Ports:
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : flag_anim_renderer_if.slave (pixel counters, frame/request pulses,
//            registered colour/enable, moving/done status, debug state)
module flag_anim_renderer
  import color_pkg::*;
#(
  parameter int FLAG_X          = 620,
  parameter int FLAG_TOP_Y      = 40,
  parameter int FLAG_HEIGHT     = 120,
  parameter int FLAG_POLE_WIDTH = 3,
  parameter int FLAG_WIDTH      = 20,
  parameter int FLAG_CLOTH_H    = 14,
  parameter int RAISE_STEP      = 2,
  parameter int WAVE_AMP        = 1,
  parameter int WAVE_COL_SHIFT  = 2,
  parameter int WAVE_DIV        = 8,
  parameter int START_RAISED    = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  flag_anim_renderer_if.slave  bus
);

  typedef enum logic [1:0] {S_LOWERED, S_RAISING, S_RAISED, S_LOWERING} state_t;
  typedef enum logic [1:0] {P_NONE, P_UP, P_DOWN} pend_t;

  localparam int DIV_W = (WAVE_DIV > 1) ? $clog2(WAVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(WAVE_DIV - 1);

  // All geometry is done in 11 bits so bounds never wrap.
  localparam logic [10:0] Y_TOP11   = 11'(FLAG_TOP_Y);
  localparam logic [10:0] Y_BOT11   = 11'(FLAG_TOP_Y + FLAG_HEIGHT - FLAG_CLOTH_H);
  localparam logic [9:0]  Y_TOP10   = 10'(FLAG_TOP_Y);
  localparam logic [9:0]  Y_BOT10   = 10'(FLAG_TOP_Y + FLAG_HEIGHT - FLAG_CLOTH_H);
  localparam logic [10:0] STEP11    = 11'(RAISE_STEP);
  localparam logic [10:0] AMP11     = 11'(WAVE_AMP);
  localparam logic [10:0] CLOTH_H11 = 11'(FLAG_CLOTH_H);
  localparam logic [10:0] FIN_X0    = 11'(FLAG_X - 1);
  localparam logic [10:0] FIN_X1    = 11'(FLAG_X + FLAG_POLE_WIDTH + 1);
  localparam logic [10:0] FIN_Y0    = 11'(FLAG_TOP_Y - 2);
  localparam logic [10:0] FIN_Y1    = 11'(FLAG_TOP_Y + 1);
  localparam logic [10:0] POLE_X0   = 11'(FLAG_X);
  localparam logic [10:0] POLE_X1   = 11'(FLAG_X + FLAG_POLE_WIDTH);
  localparam logic [10:0] POLE_Y1   = 11'(FLAG_TOP_Y + FLAG_HEIGHT);
  localparam logic [10:0] CLOTH_X1  = 11'(FLAG_X + FLAG_WIDTH);

  state_t           r_state, w_state_nxt, w_turn;
  pend_t            r_pending, w_pending_nxt, w_req;
  logic [9:0]       r_cloth_y, w_cloth_nxt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_phase;
  logic             r_done, w_done_nxt;
  rgb_t             r_color, w_color;
  logic             r_enable, w_enable;

  logic [10:0] w_cy11, w_up11, w_dn11;
  logic [10:0] w_x11, w_y11, w_d, w_cloth_top;
  logic [1:0]  w_idx;
  logic        w_finial, w_pole, w_cloth;

  // Request capture: a lone request wins; simultaneous raise+lower is ignored.
  // On frame_start the held request is consumed and a same-cycle request is kept
  // for the following frame.
  always_comb begin
    w_req = P_NONE;
    if (bus.raise_req && !bus.lower_req) w_req = P_UP;
    else if (bus.lower_req && !bus.raise_req) w_req = P_DOWN;
    w_pending_nxt = r_pending;
    if (bus.frame_start || (w_req != P_NONE)) w_pending_nxt = w_req;
  end

  // Next-state: direction change first, then one step in the new direction.
  always_comb begin
    w_state_nxt = r_state;
    w_cloth_nxt = r_cloth_y;
    w_done_nxt  = 1'b0;
    w_turn      = r_state;
    w_cy11      = {1'b0, r_cloth_y};
    w_up11      = w_cy11 - STEP11;
    w_dn11      = w_cy11 + STEP11;
    if (bus.frame_start) begin
      unique case (r_state)
        S_LOWERED, S_LOWERING: if (r_pending == P_UP)   w_turn = S_RAISING;
        S_RAISED,  S_RAISING:  if (r_pending == P_DOWN) w_turn = S_LOWERING;
        default: w_turn = r_state;
      endcase
      w_state_nxt = w_turn;
      if (w_turn == S_RAISING) begin
        // Saturate: the subtraction is only used when it stays at/above the top.
        w_cloth_nxt = (w_cy11 >= (Y_TOP11 + STEP11)) ? w_up11[9:0] : Y_TOP10;
        if (w_cloth_nxt == Y_TOP10) begin
          w_state_nxt = S_RAISED;
          w_done_nxt  = 1'b1;
        end
      end else if (w_turn == S_LOWERING) begin
        w_cloth_nxt = (w_dn11 >= Y_BOT11) ? Y_BOT10 : w_dn11[9:0];
        if (w_cloth_nxt == Y_BOT10) begin
          w_state_nxt = S_LOWERED;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  // Pixel classification from the current x,y and registered animation state.
  always_comb begin
    w_x11 = {1'b0, bus.x};
    w_y11 = {1'b0, bus.y};
    // Wave segment index; only meaningful when x >= FLAG_X (cloth gated below).
    w_idx = 2'((w_x11 - POLE_X0) >> WAVE_COL_SHIFT) + r_phase;
    unique case (w_idx)
      2'd0:    w_d = 11'd0;
      2'd2:    w_d = AMP11 << 1;
      default: w_d = AMP11;
    endcase
    w_cloth_top = {1'b0, r_cloth_y} + w_d;
    w_finial = (w_x11 >= FIN_X0) && (w_x11 < FIN_X1) &&
               (w_y11 >= FIN_Y0) && (w_y11 < FIN_Y1);
    w_pole   = (w_x11 >= POLE_X0) && (w_x11 < POLE_X1) &&
               (w_y11 >= Y_TOP11) && (w_y11 < POLE_Y1);
    w_cloth  = (w_x11 >= POLE_X0) && (w_x11 < CLOTH_X1) &&
               (w_y11 >= w_cloth_top) && (w_y11 < (w_cloth_top + CLOTH_H11));
    w_color  = BLACK;
    w_enable = 1'b1;
    if (w_finial)     w_color = FLAG_GOLD;
    else if (w_pole)  w_color = IC_SILVER;
    else if (w_cloth) w_color = FLAG_GREEN;
    else              w_enable = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= (START_RAISED != 0) ? S_RAISED : S_LOWERED;
      r_cloth_y <= (START_RAISED != 0) ? Y_TOP10 : Y_BOT10;
      r_pending <= P_NONE;
      r_div_cnt <= '0;
      r_phase   <= 2'd0;
      r_done    <= 1'b0;
      r_color   <= BLACK;
      r_enable  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cloth_y <= w_cloth_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
      r_color   <= w_color;
      r_enable  <= w_enable;
      if (bus.frame_start) begin
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt <= '0;
          r_phase   <= r_phase + 2'd1;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.color       = r_color;
  assign bus.enable      = r_enable;
  assign bus.done        = r_done;
  assign bus.moving      = (r_state == S_RAISING) || (r_state == S_LOWERING);
  assign bus.dbg_state   = r_state;
  assign bus.dbg_cloth_y = r_cloth_y;

endmodule

// File: tb/tb_flag_anim_renderer.sv
module tb_flag_anim_renderer;
  import color_pkg::*;

  localparam int Y_TOP = 40;
  localparam int Y_BOT = 40 + 120 - 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_anim_renderer_if bus ();

  flag_anim_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int scan_k   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cloth is described by its position and the position it is heading for;
  // it moves whenever the two differ. Wave phase is frames/8 mod 4.
  int   m_y, m_target_y, m_pending, m_frames, m_req;
  rgb_t exp_color;
  logic exp_en, exp_done;

  function automatic void pix(input int px, input int py, input int cy, input int ph,
                              output rgb_t col, output logic en);
    int c, idx, d;
    col = BLACK;
    en  = 1'b0;
    if (px >= 619 && px < 624 && py >= 38 && py < 41) begin
      col = FLAG_GOLD; en = 1'b1;
    end else if (px >= 620 && px < 623 && py >= 40 && py < 160) begin
      col = IC_SILVER; en = 1'b1;
    end else if (px >= 620 && px < 640) begin
      c   = px - 620;
      idx = ((c / 4) + ph) % 4;
      d   = (idx == 0) ? 0 : (idx == 2) ? 2 : 1;
      if (py >= cy + d && py < cy + d + 14) begin
        col = FLAG_GREEN; en = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = Y_BOT; m_target_y = Y_BOT; m_pending = 0; m_frames = 0;
      exp_color = BLACK; exp_en = 1'b0; exp_done = 1'b0;
    end else begin
      pix(int'(bus.x), int'(bus.y), m_y, (m_frames / 8) % 4, exp_color, exp_en);
      m_req = (bus.raise_req && !bus.lower_req) ? 1 :
              (bus.lower_req && !bus.raise_req) ? 2 : 0;
      exp_done = 1'b0;
      if (bus.frame_start) begin
        if (m_pending == 1) m_target_y = Y_TOP;
        if (m_pending == 2) m_target_y = Y_BOT;
        if (m_y > m_target_y) begin
          m_y = (m_y - 2 < m_target_y) ? m_target_y : m_y - 2;
          if (m_y == m_target_y) exp_done = 1'b1;
        end else if (m_y < m_target_y) begin
          m_y = (m_y + 2 > m_target_y) ? m_target_y : m_y + 2;
          if (m_y == m_target_y) exp_done = 1'b1;
        end
        m_pending = m_req;
        m_frames++;
      end else if (m_req != 0) begin
        m_pending = m_req;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("sb_color",   bus.color,       exp_color);
      check("sb_enable",  bus.enable,      exp_en);
      check("sb_done",    bus.done,        exp_done);
      check("sb_moving",  bus.moving,      (m_y != m_target_y));
      check("sb_cloth_y", bus.dbg_cloth_y, m_y);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.frame_start = 1'b0; bus.raise_req = 1'b0; bus.lower_req = 1'b0;
      bus.x = 10'(614 + (scan_k * 7) % 32);
      if (scan_k % 2 == 0) bus.y = 10'(36 + (scan_k * 13) % 131);
      else                 bus.y = 10'(m_y - 4 + (scan_k * 5) % 23);
      scan_k++;
    end
  endtask

  task automatic pulse(input logic r, input logic l);
    @(negedge clk); bus.raise_req = r; bus.lower_req = l;
    @(negedge clk); bus.raise_req = 1'b0; bus.lower_req = 1'b0;
  endtask

  task automatic frame_req(input logic r, input logic l);
    @(negedge clk); bus.frame_start = 1'b1; bus.raise_req = r; bus.lower_req = l;
    @(negedge clk); bus.frame_start = 1'b0; bus.raise_req = 1'b0; bus.lower_req = 1'b0;
  endtask

  task automatic frame();
    frame_req(1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin frame(); idle(2); end
  endtask

  task automatic pix_check(input string name, input int px, input int py,
                           input logic en, input rgb_t col);
    @(negedge clk); bus.x = 10'(px); bus.y = 10'(py);
    @(negedge clk);
    check({name, "_en"}, bus.enable, en);
    check({name, "_col"}, bus.color, col);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.raise_req = 1'b0; bus.lower_req = 1'b0;
    bus.x = 10'd621; bus.y = 10'd100;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_color",  bus.color,  BLACK);
    check("rst_enable", bus.enable, 1'b0);
    check("rst_moving", bus.moving, 1'b0);
    check("rst_done",   bus.done,   1'b0);
    check("rst_cloth",  bus.dbg_cloth_y, 10'd146);
    @(negedge clk); rst_n = 1'b1;

    // static pixels at phase 0, cloth at 146
    pix_check("pole",        621, 100, 1'b1, IC_SILVER);
    pix_check("cloth_wave",  630, 150, 1'b1, FLAG_GREEN);
    pix_check("cloth_gap",   630, 147, 1'b0, BLACK);
    pix_check("finial",      619,  38, 1'b1, FLAG_GOLD);
    pix_check("finial_edge", 624,  38, 1'b0, BLACK);
    pix_check("cloth_right", 639, 159, 1'b1, FLAG_GREEN);
    pix_check("cloth_xend",  640, 150, 1'b0, BLACK);
    pix_check("cloth_bot",   639, 160, 1'b0, BLACK);
    pix_check("left_of",     619, 150, 1'b0, BLACK);

    // full raise: 53 frames 146 -> 40
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 53; i++) begin
      frame();
      if (i == 1) begin
        check("raise_first_y", bus.dbg_cloth_y, 10'd144);
        check("raise_moving",  bus.moving, 1'b1);
      end
      if (i == 53) begin
        check("raise_done",   bus.done, 1'b1);
        check("raise_top_y",  bus.dbg_cloth_y, 10'd40);
        check("raise_stop",   bus.moving, 1'b0);
      end else begin
        check("raise_no_done", bus.done, 1'b0);
      end
      idle(2);
    end

    // full lower back to 146
    pulse(1'b0, 1'b1);
    frames(52);
    frame();
    check("lower_done",  bus.done, 1'b1);
    check("lower_bot_y", bus.dbg_cloth_y, 10'd146);
    idle(2);

    // reverse mid-flight
    pulse(1'b1, 1'b0);
    frames(10);
    check("rev_mid_y", bus.dbg_cloth_y, 10'd126);
    pulse(1'b0, 1'b1);
    frame();
    check("rev_turn_y",   bus.dbg_cloth_y, 10'd128);
    check("rev_moving",   bus.moving, 1'b1);
    check("rev_state",    bus.dbg_state, 2'd3);
    idle(2);
    frames(8);
    frame();
    check("rev_done",  bus.done, 1'b1);
    check("rev_bot_y", bus.dbg_cloth_y, 10'd146);
    idle(2);

    // simultaneous requests ignored; lower while lowered dropped
    pulse(1'b1, 1'b1);
    frames(5);
    check("both_y",      bus.dbg_cloth_y, 10'd146);
    check("both_moving", bus.moving, 1'b0);
    pulse(1'b0, 1'b1);
    frames(2);
    check("drop_y",      bus.dbg_cloth_y, 10'd146);
    check("drop_moving", bus.moving, 1'b0);

    // request coincident with frame_start waits one frame
    frame_req(1'b1, 1'b0);
    check("coinc_hold_y", bus.dbg_cloth_y, 10'd146);
    idle(2);
    frame();
    check("coinc_step_y", bus.dbg_cloth_y, 10'd144);
    idle(2);
    pulse(1'b0, 1'b1);
    frame();
    check("coinc_back_done", bus.done, 1'b1);
    idle(2);

    // wave phases from a fresh reset (phase 0), column 630 (segment 2)
    do_reset();
    pix_check("ph0_147", 630, 147, 1'b0, BLACK);
    pix_check("ph0_148", 630, 148, 1'b1, FLAG_GREEN);
    pix_check("ph0_pole", 620, 146, 1'b1, IC_SILVER);
    frames(8);
    pix_check("ph1_147", 630, 147, 1'b1, FLAG_GREEN);
    pix_check("ph1_146", 630, 146, 1'b0, BLACK);
    pix_check("ph1_pole", 620, 146, 1'b1, IC_SILVER);
    frames(8);
    pix_check("ph2_146", 630, 146, 1'b1, FLAG_GREEN);
    frames(8);
    pix_check("ph3_146", 630, 146, 1'b0, BLACK);
    pix_check("ph3_147", 630, 147, 1'b1, FLAG_GREEN);
    frames(8);
    pix_check("wrap_147", 630, 147, 1'b0, BLACK);
    pix_check("wrap_148", 630, 148, 1'b1, FLAG_GREEN);

    // reset in the middle of a raise
    pulse(1'b1, 1'b0);
    frames(23);
    check("mid_y",      bus.dbg_cloth_y, 10'd100);
    check("mid_moving", bus.moving, 1'b1);
    @(negedge clk); bus.x = 10'd621; bus.y = 10'd100;
    @(negedge clk);
    check("mid_pole_en", bus.enable, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_color",  bus.color,  BLACK);
    check("arst_enable", bus.enable, 1'b0);
    check("arst_moving", bus.moving, 1'b0);
    check("arst_done",   bus.done,   1'b0);
    check("arst_cloth",  bus.dbg_cloth_y, 10'd146);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames(3);
    check("post_rst_y",      bus.dbg_cloth_y, 10'd146);
    check("post_rst_moving", bus.moving, 1'b0);
    idle(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
